zbt_port_arbiter: RTL
=====================

Name: zbt_port_arbiter

Overview:
- Shares one ZBT SRAM port among four pixel requesters: 0 = ntsc capture write, 1 = lpf read/write, 2 = projective-transform write, 3 = vga read.
- Each requester uses the flag/done handshake. The arbiter grants at most one access per cycle and drives the registered ZBT address, data and write-enable.
- Read data is returned after the fixed ZBT pipeline latency.
- One instance sits between the pixel engines and each of the mem0/mem1 banks.

Parameters:
- LOG_ADDR, 19, ZBT word-address width
- LOG_MEM, 36, ZBT data width
- READ_LAT, 2, cycles from address on mem_addr to valid mem_read
- VGA_PRIORITY, 1, 1 = requester 3 has strict priority; 0 = pure round robin
- MAX_WAIT, 16, cycles a pending non-vga requester may wait before it is forced to the top

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_flag  in  4  per-requester access request, held until its done pulse
- req_wr  in  4  per-requester: 1 = write, 0 = read
- req_addr  in  4*LOG_ADDR  packed addresses; requester i occupies bits [i*LOG_ADDR +: LOG_ADDR]
- req_data  in  4*LOG_MEM  packed write data, same packing
- done  out  4  one-cycle grant pulse per requester
- rd_valid  out  4  one-cycle read-return pulse per requester
- rd_data  out  LOG_MEM  read data, qualified by rd_valid
- mem_addr  out  LOG_ADDR  ZBT address
- mem_write  out  LOG_MEM  ZBT write data
- mem_wr  out  1  ZBT write enable
- mem_read  in  LOG_MEM  ZBT read data

Behaviour:
- Reset (synchronous, active-high): done=0, rd_valid=0, rd_data=0, mem_addr=0, mem_write=0, mem_wr=0, rr_ptr=0, all wait counters=0, read-tag pipeline cleared.
- Eligibility: req_flag[i] high AND done[i] currently low. A requester is masked in the cycle its done is high, so a flag held until done is sampled is never double-granted.
- Selection, combinational each cycle, evaluated in this order:
  1. Forced: any non-vga requester whose wait counter == MAX_WAIT; lowest index wins among forced requesters.
  2. Otherwise, if VGA_PRIORITY=1 and requester 3 is eligible: grant 3.
  3. Otherwise round robin: search from rr_ptr upward, mod 4, and take the first eligible requester.
- At the posedge after a grant to i:
  - done[i]=1 for exactly one cycle.
  - mem_addr = req_addr[i], mem_write = req_data[i], mem_wr = req_wr[i].
  - rr_ptr = (i+1) mod 4.
- Idle cycle (nothing eligible): mem_wr=0; mem_addr and mem_write hold their previous values; done=0; rr_ptr unchanged.
- Wait counters (requesters 0..2 only):
  - Increment while eligible and not granted; saturate at MAX_WAIT.
  - Clear on grant or when req_flag drops.
  - A forced grant does not bypass the done-mask.
- Read tagging:
  - Each issued read pushes {valid, id[1:0]} into a READ_LAT-deep shift register; writes and idle cycles push invalid.
  - When the tag exits the shift register, at the cycle mem_read holds the data, the next posedge sets rd_data = mem_read and rd_valid[id] = 1 for one cycle.
  - Read latency from done[i] to rd_valid[i] is READ_LAT cycles.
  - rd_data holds its value between returns.
- Throughput: one access per cycle, back-to-back, with no bubble between different requesters. A single requester that holds its flag gets at most one grant every 2 cycles, because of the done-mask.
- Simultaneous events:
  - A write grant and a read return in the same cycle are independent.
  - Multiple forced requesters: lowest index wins; the others keep saturated counters.
- Reset mid-operation: in-flight read tags are discarded. No rd_valid is produced for reads issued before reset.

Test Plan:
- After reset with no requests -> done=0, rd_valid=0, mem_wr=0, mem_addr=0 for 10 cycles.
- Requester 0 write, addr=5, data=1, flag held until done -> done[0] one cycle after flag; mem_addr=5, mem_write=1, mem_wr=1 in that cycle; no second grant while done is high.
- All four flags constant, VGA_PRIORITY=0 -> grants cycle 0,1,2,3,0,... one per cycle; each done is a single-cycle pulse.
- VGA_PRIORITY=1, vga reads continuous, requester 2 writing -> requester 2 granted no later than MAX_WAIT=16 cycles after raising its flag, then vga resumes.
- Requester 3 reads addr=7 (dummy memory returns 3000 at addr 7) -> rd_valid[3]=1 with rd_data=3000 exactly READ_LAT=2 cycles after done[3]; other rd_valid bits stay 0.
- Read issued, reset asserted the next cycle -> no rd_valid at any point afterwards; all outputs at reset values.

Source files
------------

// File: rtl/zbt_port_arbiter.sv
// Four-way arbiter sharing one ZBT SRAM port between the pixel engines.
// Grants one flag/done access per cycle and routes pipelined read data back to its requester.
module zbt_port_arbiter #(
  parameter int LOG_ADDR     = 19,
  parameter int LOG_MEM      = 36,
  parameter int READ_LAT     = 2,
  parameter int VGA_PRIORITY = 1,
  parameter int MAX_WAIT     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req_flag,
  input  logic [3:0]            req_wr,
  input  logic [4*LOG_ADDR-1:0] req_addr,
  input  logic [4*LOG_MEM-1:0]  req_data,
  output logic [3:0]            done,
  output logic [3:0]            rd_valid,
  output logic [LOG_MEM-1:0]    rd_data,
  output logic [LOG_ADDR-1:0]   mem_addr,
  output logic [LOG_MEM-1:0]    mem_write,
  output logic                  mem_wr,
  input  logic [LOG_MEM-1:0]    mem_read
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]                        rr_ptr_r;
  logic [WAIT_W-1:0]                 wait_r [3];
  logic [READ_LAT-1:0]               tag_v_r;
  logic [READ_LAT-1:0][1:0]          tag_id_r;

  logic [3:0]          elig_s;
  logic [3:0]          rot_s;
  logic [2:0]          forced_vec_s;
  logic [1:0]          forced_id_s;
  logic [1:0]          rr_id_s;
  logic                gnt_valid_s;
  logic [1:0]          gnt_id_s;
  logic [LOG_ADDR-1:0] addr_a_s [4];
  logic [LOG_MEM-1:0]  data_a_s [4];

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    casez (v)
      4'b???1: first_set = 2'd0;
      4'b??10: first_set = 2'd1;
      4'b?100: first_set = 2'd2;
      4'b1000: first_set = 2'd3;
      default: first_set = 2'd0;
    endcase
  endfunction

  // Rotate right so that bit j of the result is v[(r + j) mod 4].
  function automatic logic [3:0] rotate_from(input logic [3:0] v, input logic [1:0] r);
    case (r)
      2'd0:    rotate_from = v;
      2'd1:    rotate_from = {v[0], v[3:1]};
      2'd2:    rotate_from = {v[1:0], v[3:2]};
      2'd3:    rotate_from = {v[2:0], v[3]};
      default: rotate_from = v;
    endcase
  endfunction

  // Unpack per-requester address and data buses.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_a_s[i] = req_addr[i*LOG_ADDR +: LOG_ADDR];
      data_a_s[i] = req_data[i*LOG_MEM +: LOG_MEM];
    end
  end

  // A requester whose done is high this cycle is masked so a held flag is not granted twice.
  assign elig_s = req_flag & ~done;

  // Candidate selection: starved requesters first, then vga priority, then round robin.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      forced_vec_s[i] = elig_s[i] && (wait_r[i] == WAIT_W'(MAX_WAIT));
    end
    forced_id_s = first_set({1'b0, forced_vec_s});
    rot_s       = rotate_from(elig_s, rr_ptr_r);
    rr_id_s     = rr_ptr_r + first_set(rot_s);
    if (forced_vec_s != 3'b000) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = forced_id_s;
    end else if ((VGA_PRIORITY != 0) && elig_s[3]) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 2'd3;
    end else if (elig_s != 4'b0000) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = rr_id_s;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 2'd0;
    end
  end

  // Issue the granted access onto the ZBT port and pulse its done.
  always_ff @(posedge clock) begin
    if (reset) begin
      done      <= 4'b0000;
      mem_addr  <= {LOG_ADDR{1'b0}};
      mem_write <= {LOG_MEM{1'b0}};
      mem_wr    <= 1'b0;
      rr_ptr_r  <= 2'd0;
    end else if (gnt_valid_s) begin
      done      <= 4'b0001 << gnt_id_s;
      mem_addr  <= addr_a_s[gnt_id_s];
      mem_write <= data_a_s[gnt_id_s];
      mem_wr    <= req_wr[gnt_id_s];
      rr_ptr_r  <= gnt_id_s + 2'd1;
    end else begin
      done      <= 4'b0000;
      mem_wr    <= 1'b0;
    end
  end

  // Starvation counters for the non-vga requesters.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        wait_r[i] <= {WAIT_W{1'b0}};
      end else if (!req_flag[i] || (gnt_valid_s && (gnt_id_s == 2'(i)))) begin
        wait_r[i] <= {WAIT_W{1'b0}};
      end else if (elig_s[i] && (wait_r[i] != WAIT_W'(MAX_WAIT))) begin
        wait_r[i] <= wait_r[i] + WAIT_W'(1);
      end else begin
        wait_r[i] <= wait_r[i];
      end
    end
  end

  // Read tags travel alongside the ZBT pipeline so returning data finds its owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v_r  <= {READ_LAT{1'b0}};
      tag_id_r <= {(2*READ_LAT){1'b0}};
    end else begin
      tag_v_r[0]  <= gnt_valid_s && !req_wr[gnt_id_s];
      tag_id_r[0] <= gnt_id_s;
      for (int k = 1; k < READ_LAT; k++) begin
        tag_v_r[k]  <= tag_v_r[k-1];
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Capture returning read data; rd_data holds between returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 4'b0000;
      rd_data  <= {LOG_MEM{1'b0}};
    end else if (tag_v_r[READ_LAT-1]) begin
      rd_valid <= 4'b0001 << tag_id_r[READ_LAT-1];
      rd_data  <= mem_read;
    end else begin
      rd_valid <= 4'b0000;
      rd_data  <= rd_data;
    end
  end

endmodule
